// File: rtl/serial_cmp_seq_if.sv
// Handshake bundle for serial_cmp_seq: operand pair in, compare flags out.
// The master drives the operands and accepts results; the slave is the comparator.
interface serial_cmp_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             agreqb;
    logic             aeqb;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, agreqb, aeqb, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, agreqb, aeqb, busy
    );
endinterface

// File: rtl/serial_cmp_seq.sv
// Serial magnitude comparator: walks one SLICE-bit compare slice across the operands, MSB first.
// Define EARLY_TERM_EN to finish as soon as the first differing slice is found.
module serial_cmp_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 2
) (
    input logic             clk,
    input logic             rst_n,
    serial_cmp_seq_if.slave cmp_io
);
    localparam int unsigned NSLICE = (SLICE == 0) ? 1 : WIDTH / SLICE;
    localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam bit          BadCfg = (SLICE == 0) ? 1'b1 : ((WIDTH % SLICE) != 0);

    if (BadCfg) begin : g_bad_cfg
        $error("serial_cmp_seq: WIDTH must be a nonzero multiple of SLICE");
    end

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              decided_q, decided_d;
    logic              gt_q, gt_d;
    logic              agreqb_q, agreqb_d;
    logic              aeqb_q, aeqb_d;

    logic [WIDTH-1:0]  a_sh, b_sh;
    logic [SLICE-1:0]  a_sl, b_sl;
    logic              term;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        agreqb_d  = agreqb_q;
        aeqb_d    = aeqb_q;
        term      = 1'b0;

        a_sh = a_q >> (SLICE * idx_q);
        b_sh = b_q >> (SLICE * idx_q);
        a_sl = a_sh[SLICE-1:0];
        b_sl = b_sh[SLICE-1:0];

        unique case (state_q)
            StIdle: begin
                if (cmp_io.in_valid) begin
                    state_d   = StCmp;
                    a_d       = cmp_io.a;
                    b_d       = cmp_io.b;
                    idx_d     = IdxW'(NSLICE - 1);
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                end
            end
            StCmp: begin
                // Once a slice differs, lower slices cannot change the outcome.
                if (!decided_q) begin
                    if (a_sl > b_sl) begin
                        gt_d      = 1'b1;
                        decided_d = 1'b1;
                    end else if (a_sl < b_sl) begin
                        gt_d      = 1'b0;
                        decided_d = 1'b1;
                    end
                end
`ifdef EARLY_TERM_EN
                term = (idx_q == '0) || decided_d;
`else
                term = (idx_q == '0);
`endif
                if (term) begin
                    state_d  = StDone;
                    agreqb_d = decided_d ? gt_d : 1'b1;
                    aeqb_d   = !decided_d;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                if (cmp_io.out_ready) begin
                    state_d  = StIdle;
                    agreqb_d = 1'b0;
                    aeqb_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            agreqb_q  <= 1'b0;
            aeqb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            agreqb_q  <= agreqb_d;
            aeqb_q    <= aeqb_d;
        end
    end

    assign cmp_io.in_ready  = (state_q == StIdle);
    assign cmp_io.out_valid = (state_q == StDone);
    assign cmp_io.busy      = (state_q != StIdle);
    assign cmp_io.agreqb    = agreqb_q;
    assign cmp_io.aeqb      = aeqb_q;
endmodule

// File: tb/tb_serial_cmp_seq.sv
// Directed and random bench for serial_cmp_seq; results checked against a queue of expected flags.
module tb_serial_cmp_seq;
    localparam int unsigned W  = 8;
    localparam int unsigned SL = 2;
    localparam int unsigned NS = W / SL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [1:0] sb[$];   // {agreqb, aeqb}

    always #5 clk = ~clk;

    serial_cmp_seq_if #(.WIDTH(W)) cmp_if ();

    serial_cmp_seq #(.WIDTH(W), .SLICE(SL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmp_io (cmp_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
        logic [W-1:0] as, bs;
        for (int k = 1; k <= NS; k++) begin
            as = a >> (SL * (NS - k));
            bs = b >> (SL * (NS - k));
            if (as[SL-1:0] != bs[SL-1:0]) return k;
        end
`endif
        return NS;
    endfunction

    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!cmp_if.in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 32'(cmp_if.in_ready), 32'd1);
        cmp_if.in_valid = 1'b1;
        cmp_if.a = a;
        cmp_if.b = b;
        sb.push_back({a >= b, a == b});
        tick();
        cmp_if.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(cmp_if.busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int lat_exp);
        int lat = 0;
        while (!cmp_if.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    endtask

    task automatic check_result(input string tag);
        logic [1:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_agreqb"}, 32'(cmp_if.agreqb), 32'(e[1]));
        check({tag, "_aeqb"}, 32'(cmp_if.aeqb), 32'(e[0]));
    endtask

    task automatic finish_op(input string tag);
        cmp_if.out_ready = 1'b1;
        tick();
        check({tag, "_idle_in_ready"}, 32'(cmp_if.in_ready), 32'd1);
        check({tag, "_idle_flags"}, {29'd0, cmp_if.out_valid, cmp_if.agreqb, cmp_if.aeqb}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(tag, a, b);
        wait_done(tag, exp_lat(a, b));
        check_result(tag);
        finish_op(tag);
    endtask

    initial begin
        int accepted;
        int cycles;
        int r;
        cmp_if.in_valid  = 1'b0;
        cmp_if.out_ready = 1'b1;
        cmp_if.a = '0;
        cmp_if.b = '0;
        #12;
        check("reset_outputs", {27'd0, cmp_if.in_ready, cmp_if.out_valid, cmp_if.agreqb,
                                cmp_if.aeqb, cmp_if.busy}, 32'b10000);
        rst_n = 1'b1;
        tick();

        run_op("t1_gt", 8'hC8, 8'h37);
        run_op("t2_eq", 8'h5A, 8'h5A);
        run_op("t3_lt_last", 8'h12, 8'h13);

        // Back-pressure: result held, new operands refused.
        cmp_if.out_ready = 1'b0;
        start_op("t4", 8'h40, 8'h80);
        wait_done("t4", exp_lat(8'h40, 8'h80));
        for (int i = 0; i < 5; i++) begin
            cmp_if.in_valid = i[0];
            cmp_if.a = 8'hFF;
            cmp_if.b = 8'h00;
            tick();
            check("t4_hold", {28'd0, cmp_if.out_valid, cmp_if.agreqb, cmp_if.aeqb,
                              cmp_if.in_ready}, 32'b1000);
        end
        cmp_if.in_valid = 1'b0;
        check_result("t4");
        finish_op("t4");

        // Reset mid-operation discards the pending compare.
        start_op("t5", 8'hFF, 8'h00);
        void'(sb.pop_back());
        rst_n = 1'b0;
        #1;
        check("t5_reset", {29'd0, cmp_if.out_valid, cmp_if.busy, cmp_if.in_ready}, 32'b001);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("t5_after", 8'h00, 8'hFF);

        // Random back-to-back traffic with random back-pressure.
        accepted = 0;
        cycles = 0;
        while (accepted < 1000 && cycles < 40000) begin
            r = $urandom_range(0, 3);
            cmp_if.in_valid  = ($urandom_range(0, 3) != 0);
            cmp_if.out_ready = $urandom_range(0, 1) == 1;
            cmp_if.a = W'($urandom);
            if (r == 0) cmp_if.b = cmp_if.a;
            else if (r == 1) cmp_if.b = cmp_if.a ^ W'(1 << $urandom_range(0, W - 1));
            else cmp_if.b = W'($urandom);
            if (cmp_if.in_valid && cmp_if.in_ready) begin
                sb.push_back({cmp_if.a >= cmp_if.b, cmp_if.a == cmp_if.b});
                accepted++;
            end
            if (cmp_if.out_valid && cmp_if.out_ready) check_result("rand");
            tick();
            cycles++;
        end
        check("rand_accepted", 32'(accepted), 32'd1000);
        cmp_if.in_valid  = 1'b0;
        cmp_if.out_ready = 1'b1;
        cycles = 0;
        while (sb.size() != 0 && cycles < 100) begin
            if (cmp_if.out_valid) check_result("drain");
            tick();
            cycles++;
        end
        check("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
